// File: rtl/turf_prog_pkg.sv
// Shared types and constants for the TURF programming sequencer.
package turf_prog_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PROG_LOW,
        ST_WAIT_INIT,
        ST_CNT_WR,
        ST_GET_WORD,
        ST_DAT_WR,
        ST_SHIFT,
        ST_PAD,
        ST_FINISH,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam logic        ADDR_CNT = 1'b0;
    localparam logic        ADDR_DAT = 1'b1;
    localparam logic [31:0] CNT_WORD = 32'h0000_001F;
    localparam logic [31:0] PAD_WORD = 32'hFFFF_FFFF;

    // The shifter's busy flag is registered, so it lags the data write.
    localparam logic [1:0]  SHIFT_GUARD_CLKS = 2'd2;

    function automatic logic [31:0] bitswap_bytes(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = w[(i / 8) * 8 + 7 - (i % 8)];
        end
        return r;
    endfunction

endpackage

// File: rtl/turf_prog_timer.sv
// Loadable down-counter with expiry flag; shared by the PROG_B pulse
// and the INIT_B wait.
module turf_prog_timer #(
    parameter int unsigned W = 21
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/turf_prog_seq.sv
// TURF configuration sequencer: PROG_B pulse, INIT_B wait, word feed to the
// shifter, DONE padding. Define TURF_PROG_BITSWAP_EN to bit-reverse each byte.
module turf_prog_seq
    import turf_prog_pkg::*;
#(
    parameter int unsigned PROG_PULSE_CLKS   = 1024,
    parameter int unsigned INIT_TIMEOUT_CLKS = 1048576,
    parameter int unsigned DONE_PAD_WORDS    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] s_tdata_i,
    input  logic        s_tvalid_i,
    output logic        s_tready_o,
    input  logic        s_tlast_i,
    output logic        sh_wr_o,
    output logic        sh_addr_o,
    output logic [31:0] sh_dat_o,
    input  logic        sh_busy_i,
    output logic        turf_prog_b_o,
    input  logic        turf_init_b_i,
    input  logic        turf_done_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [23:0] word_count_o
);

    localparam int unsigned TMR_MAX = (PROG_PULSE_CLKS > INIT_TIMEOUT_CLKS) ?
                                      PROG_PULSE_CLKS : INIT_TIMEOUT_CLKS;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned PAD_W   = (DONE_PAD_WORDS > 0) ? $clog2(DONE_PAD_WORDS + 1) : 1;

    localparam logic [TMR_W-1:0] PROG_LOAD = TMR_W'(PROG_PULSE_CLKS - 1);
    localparam logic [TMR_W-1:0] INIT_LOAD = TMR_W'(INIT_TIMEOUT_CLKS - 1);
    localparam logic [PAD_W-1:0] PAD_MAX   = PAD_W'(DONE_PAD_WORDS);

    state_e             state_q, state_d;
    logic               tmr_load, tmr_en, tmr_expired;
    logic [TMR_W-1:0]   tmr_load_val;
    logic [2:0]         init_sync_q;
    logic               init_ok;
    logic [31:0]        word_in, word_q;
    logic               last_q, pad_active_q;
    logic [PAD_W-1:0]   pad_cnt_q;
    logic [1:0]         guard_q;
    logic [23:0]        word_count_q;
    logic               run_start;

`ifdef TURF_PROG_BITSWAP_EN
    assign word_in = bitswap_bytes(s_tdata_i);
`else
    assign word_in = s_tdata_i;
`endif

    // Two synchroniser stages plus one more so INIT_B must be high on two consecutive synced samples.
    assign init_ok   = init_sync_q[1] && init_sync_q[2];
    assign run_start = (state_d == ST_PROG_LOW) && (state_q != ST_PROG_LOW);

    turf_prog_timer #(.W(TMR_W)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = PROG_LOAD;
        tmr_en       = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d  = ST_PROG_LOW;
                    tmr_load = 1'b1;
                end
            end
            ST_PROG_LOW: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_d      = ST_WAIT_INIT;
                    tmr_load     = 1'b1;
                    tmr_load_val = INIT_LOAD;
                end
            end
            ST_WAIT_INIT: begin
                tmr_en = 1'b1;
                if (init_ok) begin
                    state_d = ST_CNT_WR;
                end else if (tmr_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_CNT_WR:   state_d = ST_GET_WORD;
            // During padding this state is only the spacer between the two writes.
            ST_GET_WORD: if (pad_active_q || s_tvalid_i) state_d = ST_DAT_WR;
            ST_DAT_WR:   state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (guard_q == '0 && !sh_busy_i) begin
                    if (pad_active_q && turf_done_i) begin
                        state_d = ST_FINISH;
                    end else if (pad_active_q || last_q) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_CNT_WR;
                    end
                end
            end
            ST_PAD: begin
                if (turf_done_i) begin
                    state_d = ST_FINISH;
                end else if (pad_cnt_q < PAD_MAX) begin
                    state_d = ST_CNT_WR;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_FINISH: state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_sync_q  <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            pad_active_q <= 1'b0;
            pad_cnt_q    <= '0;
            guard_q      <= '0;
            word_count_q <= '0;
        end else begin
            init_sync_q <= {init_sync_q[1:0], turf_init_b_i};

            if (run_start) begin
                last_q       <= 1'b0;
                pad_active_q <= 1'b0;
                pad_cnt_q    <= '0;
                word_count_q <= '0;
            end

            if (state_q == ST_GET_WORD) begin
                if (pad_active_q) begin
                    word_q <= PAD_WORD;
                end else if (s_tvalid_i) begin
                    word_q <= word_in;
                    last_q <= s_tlast_i;
                    if (word_count_q != '1) begin
                        word_count_q <= word_count_q + 24'd1;
                    end
                end
            end

            if (state_q == ST_DAT_WR) begin
                guard_q <= SHIFT_GUARD_CLKS;
            end else if (guard_q != '0) begin
                guard_q <= guard_q - 2'd1;
            end

            if (state_q == ST_PAD && state_d == ST_CNT_WR) begin
                pad_active_q <= 1'b1;
                pad_cnt_q    <= pad_cnt_q + PAD_W'(1);
            end
        end
    end

    assign s_tready_o    = (state_q == ST_GET_WORD) && !pad_active_q;
    assign sh_wr_o       = (state_q == ST_CNT_WR) || (state_q == ST_DAT_WR);
    assign sh_addr_o     = (state_q == ST_DAT_WR) ? ADDR_DAT : ADDR_CNT;
    assign sh_dat_o      = (state_q == ST_CNT_WR) ? CNT_WORD :
                           (state_q == ST_DAT_WR) ? word_q : 32'h0;
    assign turf_prog_b_o = (state_q != ST_PROG_LOW);
    assign busy_o        = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign done_o        = (state_q == ST_FINISH) || (state_q == ST_DONE);
    assign err_o         = (state_q == ST_ERROR);
    assign word_count_o  = word_count_q;

endmodule

// File: tb/tb_turf_prog_seq.sv
// Scoreboard bench for turf_prog_seq with behavioural TURF and shifter models.
module tb_turf_prog_seq;

    localparam int PROG_CLKS = 16;
    localparam int INIT_CLKS = 100;
    localparam int PAD_WORDS = 2;
    localparam int WAIT_MAX  = 30000;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i;
    logic [31:0] s_tdata_i;
    logic        s_tvalid_i, s_tready_o, s_tlast_i;
    logic        sh_wr_o, sh_addr_o, sh_busy_i;
    logic [31:0] sh_dat_o;
    logic        turf_prog_b_o, turf_init_b_i, turf_done_i;
    logic        busy_o, done_o, err_o;
    logic [23:0] word_count_o;

    typedef struct packed {
        logic        addr;
        logic [31:0] dat;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] stim_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          dat_writes = 0;
    int          done_tgt   = 32'h7FFF_FFFF;
    bit          done_early = 1'b0;
    int          sh_cnt  = 0;
    int          sh_time = 8;
    int          sh_dly  = 0;
    logic        mon_prev_wr = 1'b0;

    always #5 clk_i = ~clk_i;

    turf_prog_seq #(
        .PROG_PULSE_CLKS   (PROG_CLKS),
        .INIT_TIMEOUT_CLKS (INIT_CLKS),
        .DONE_PAD_WORDS    (PAD_WORDS)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .s_tdata_i     (s_tdata_i),
        .s_tvalid_i    (s_tvalid_i),
        .s_tready_o    (s_tready_o),
        .s_tlast_i     (s_tlast_i),
        .sh_wr_o       (sh_wr_o),
        .sh_addr_o     (sh_addr_o),
        .sh_dat_o      (sh_dat_o),
        .sh_busy_i     (sh_busy_i),
        .turf_prog_b_o (turf_prog_b_o),
        .turf_init_b_i (turf_init_b_i),
        .turf_done_i   (turf_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .word_count_o  (word_count_o)
    );

    // TURF raises DONE once a chosen number of data words have reached the shifter.
    assign turf_done_i = done_early || (dat_writes >= done_tgt);

    // Shifter: busy for sh_time clocks, appearing sh_dly clocks after a data write.
    assign sh_busy_i = (sh_cnt != 0) && (sh_cnt <= sh_time);
    always @(posedge clk_i) begin
        if (rst_i)                   sh_cnt <= 0;
        else if (sh_wr_o && sh_addr_o) sh_cnt <= sh_dly + sh_time;
        else if (sh_cnt != 0)        sh_cnt <= sh_cnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef TURF_PROG_BITSWAP_EN
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i++)
                r[8*b + i] = w[8*b + 7 - i];
`endif
        return r;
    endfunction

    // Monitor: every shifter write must match the head of the expectation queue.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk_i);
            if (sh_wr_o) begin
                check("wr_not_back_to_back", {31'd0, mon_prev_wr}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got addr %0d dat 0x%08h, required no write",
                             sh_addr_o, sh_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {31'd0, sh_addr_o}, {31'd0, e.addr});
                    check("wr_dat", sh_dat_o, e.dat);
                end
                if (sh_addr_o) dat_writes++;
            end
            mon_prev_wr = sh_wr_o;
        end
    end

    task automatic pulse_start();
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    task automatic drive_words(input bit stall);
        int guard;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (stall && i == 1) begin
                s_tvalid_i = 1'b0;
                repeat (50) @(posedge clk_i);
                #1;
            end else if ($urandom_range(0, 3) == 0) begin
                s_tvalid_i = 1'b0;
                repeat ($urandom_range(1, 6)) @(posedge clk_i);
                #1;
            end
            s_tdata_i  = stim_q[i];
            s_tlast_i  = (i == stim_q.size() - 1);
            s_tvalid_i = 1'b1;
            guard = 0;
            @(negedge clk_i);
            while (!s_tready_o && guard < WAIT_MAX) begin
                guard++;
                @(negedge clk_i);
            end
            if (guard >= WAIT_MAX) begin
                n_checks++;
                n_fail++;
                $display("FAIL handshake_timeout: word %0d not accepted within %0d clk", i, WAIT_MAX);
                s_tvalid_i = 1'b0;
                return;
            end
            @(posedge clk_i); #1;
            s_tvalid_i = 1'b0;
            s_tlast_i  = 1'b0;
            s_tdata_i  = $urandom;
        end
    endtask

    // One configuration run over stim_q. pad_k: pad words after which TURF raises DONE.
    task automatic run(input int pad_k, input bit early, input bit init_fail,
                       input bit stall, input int t_shift, input int dly);
        int  nw, pads, cnt;
        bit  exp_done;
        nw       = init_fail ? 0 : stim_q.size();
        pads     = early ? 0 : ((pad_k < PAD_WORDS) ? pad_k : PAD_WORDS);
        exp_done = !init_fail && (early || pad_k <= PAD_WORDS);
        sh_time  = t_shift;
        sh_dly   = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
        if (!init_fail) begin
            foreach (stim_q[i]) begin
                exp_q.push_back('{addr: 1'b0, dat: 32'h0000_001F});
                exp_q.push_back('{addr: 1'b1, dat: model_word(stim_q[i])});
            end
            repeat (pads) begin
                exp_q.push_back('{addr: 1'b0, dat: 32'h0000_001F});
                exp_q.push_back('{addr: 1'b1, dat: 32'hFFFF_FFFF});
            end
        end
        done_early    = early;
        done_tgt      = dat_writes + nw + pad_k;
        turf_init_b_i = 1'b0;
        pulse_start();
        fork
            begin
                cnt = 0;
                @(negedge clk_i);
                check("busy_after_start", {31'd0, busy_o}, 32'd1);
                while (!turf_prog_b_o && cnt < 4 * PROG_CLKS) begin
                    cnt++;
                    @(negedge clk_i);
                end
                check("prog_b_low_clks", cnt, PROG_CLKS);
                if (init_fail) begin
                    cnt = 0;
                    while (!err_o && cnt < 4 * INIT_CLKS) begin
                        @(negedge clk_i);
                        cnt++;
                    end
                    check("init_timeout_clks", cnt, INIT_CLKS);
                end else begin
                    repeat (4) @(negedge clk_i);
                    turf_init_b_i = 1'b1;
                end
            end
            begin
                if (!init_fail) drive_words(stall);
            end
        join
        cnt = 0;
        while (busy_o && cnt < WAIT_MAX) begin
            @(negedge clk_i);
            cnt++;
        end
        check("run_ends_in_budget", {31'd0, cnt < WAIT_MAX}, 32'd1);
        check("done_o", {31'd0, done_o}, {31'd0, exp_done});
        check("err_o", {31'd0, err_o}, {31'd0, !exp_done});
        check("word_count_o", {8'd0, word_count_o}, nw);
        check("prog_b_idle", {31'd0, turf_prog_b_o}, 32'd1);
        check("tready_idle", {31'd0, s_tready_o}, 32'd0);
        check("writes_outstanding", exp_q.size(), 32'd0);
        exp_q.delete();
        stim_q.delete();
    endtask

    task automatic reset_mid_shift();
        int cnt;
        logic [31:0] exp_w;
`ifdef TURF_PROG_BITSWAP_EN
        exp_w = 32'h8040_C001;
`else
        exp_w = 32'h0102_0380;
`endif
        exp_q.push_back('{addr: 1'b0, dat: 32'h0000_001F});
        exp_q.push_back('{addr: 1'b1, dat: exp_w});
        sh_time = 40; sh_dly = 0; done_early = 1'b0; done_tgt = 32'h7FFF_FFFF;
        turf_init_b_i = 1'b0;
        pulse_start();
        repeat (PROG_CLKS + 3) @(posedge clk_i);
        #1 turf_init_b_i = 1'b1;
        s_tdata_i = 32'h0102_0380; s_tlast_i = 1'b0; s_tvalid_i = 1'b1;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 2000) begin
            @(negedge clk_i);
            cnt++;
        end
        check("rst_test_writes_seen", exp_q.size(), 32'd0);
        @(posedge clk_i); #1 s_tvalid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_prog_b", {31'd0, turf_prog_b_o}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_tready", {31'd0, s_tready_o}, 32'd0);
        check("rst_word_count", {8'd0, word_count_o}, 32'd0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst_i = 1'b1; start_i = 1'b0; s_tdata_i = '0; s_tvalid_i = 1'b0;
        s_tlast_i = 1'b0; turf_init_b_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_prog_b", {31'd0, turf_prog_b_o}, 32'd1);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, done_o}, 32'd0);
        check("reset_err", {31'd0, err_o}, 32'd0);
        check("reset_tready", {31'd0, s_tready_o}, 32'd0);
        check("reset_sh_wr", {31'd0, sh_wr_o}, 32'd0);
        check("reset_sh_dat", sh_dat_o, 32'd0);
        check("reset_word_count", {8'd0, word_count_o}, 32'd0);

        // Directed 3-word stream, DONE after one pad word, 512-clk shifter.
        stim_q = '{32'hAA99_5566, 32'h1122_3344, 32'h2000_0000};
        run(1, 1'b0, 1'b0, 1'b0, 512, 1);

        // INIT_B never rises.
        run(0, 1'b0, 1'b1, 1'b0, 8, 0);

        // DONE never arrives: both pad words written, then error.
        stim_q = '{$urandom, $urandom};
        run(5, 1'b0, 1'b0, 1'b0, 20, -1);

        // Source stall of 50 clk, busy appearing only after the guard window.
        stim_q = '{$urandom, $urandom, $urandom, $urandom};
        run(1, 1'b0, 1'b0, 1'b1, 5, 2);

        // DONE high from the start: all words still fed, no padding.
        stim_q = '{$urandom, $urandom, $urandom};
        run(0, 1'b1, 1'b0, 1'b0, 10, -1);

        // Abort during SHIFT, then restart from scratch.
        reset_mid_shift();
        stim_q = '{32'h0102_0380, $urandom};
        run(2, 1'b0, 1'b0, 1'b0, 12, -1);

        for (int r = 0; r < 6; r++) begin
            int nw;
            nw = $urandom_range(1, 5);
            for (int i = 0; i < nw; i++) stim_q.push_back($urandom);
            run($urandom_range(0, 3), ($urandom_range(0, 4) == 0), 1'b0, 1'b0,
                $urandom_range(3, 60), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/turf_prog_seq.md
Name: turf_prog_seq

Overview:
Sequencer sitting directly upstream of the TURF programming shifter (two-register write port: addr 0 = bit count/mode, addr 1 = 32-bit data word).
- Accepts a TURF bitstream as a 32-bit word stream from the host FIFO.
- Pulses PROG_B and waits for INIT_B.
- Feeds each word to the shifter, pacing on the shifter's busy flag.
- Pads until DONE, then reports status.

Parameters:
PROG_PULSE_CLKS, 1024, clocks PROG_B is held low.
INIT_TIMEOUT_CLKS, 1048576, max clocks waiting for INIT_B high after PROG_B release.
DONE_PAD_WORDS, 8, max all-ones pad words written after last word while awaiting DONE.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  one-cycle pulse; begins a configuration (ignored unless IDLE/DONE/ERROR)
s_tdata_i  in  32  bitstream word
s_tvalid_i  in  1  word valid
s_tready_o  out  1  word accepted when s_tvalid_i && s_tready_o
s_tlast_i  in  1  marks final bitstream word
sh_wr_o  out  1  shifter register write strobe
sh_addr_o  out  1  shifter register select (0 = count/mode, 1 = data)
sh_dat_o  out  32  shifter write data
sh_busy_i  in  1  shifter shifting
turf_prog_b_o  out  1  TURF PROG_B, active low
turf_init_b_i  in  1  TURF INIT_B
turf_done_i  in  1  TURF DONE
busy_o  out  1  sequence in progress
done_o  out  1  configuration succeeded (sticky until next start_i)
err_o  out  1  init timeout or DONE not seen (sticky until next start_i)
word_count_o  out  24  words accepted this run (saturates at 0xFFFFFF)

Behaviour:
Reset values:
- turf_prog_b_o=1; all other outputs 0; state IDLE.
- Reset mid-sequence aborts immediately; PROG_B returns high the next cycle.

States:
- IDLE
- PROG_LOW: prog_b=0, count PROG_PULSE_CLKS, then go to WAIT_INIT.
- WAIT_INIT: prog_b=1.
  - Requires turf_init_b_i high for 2 consecutive samples (synchronised) to go to CNT_WR.
  - Counter reaching INIT_TIMEOUT_CLKS goes to ERROR.
- CNT_WR: single-cycle sh_wr_o=1, addr 0, dat = 0x0000001F (bit31=0 selects SelectMAP/serial mode, 31 = 32 bits minus 1). Go to GET_WORD.
- GET_WORD: s_tready_o=1 only in this state.
  - On handshake: latch word and tlast, increment word_count_o, go to DAT_WR.
- DAT_WR: single-cycle sh_wr_o=1, addr 1, dat = latched word. Go to SHIFT.
- SHIFT: ignore sh_busy_i for the first 2 cycles (shifter busy is registered). Then, when sh_busy_i=0:
  - not last: go to CNT_WR;
  - last: go to PAD;
  - pad in progress and DONE seen: go to FINISH.
- PAD: if turf_done_i=1, go to FINISH.
  - Else if pad count < DONE_PAD_WORDS: write count then 0xFFFFFFFF (reusing the CNT_WR/DAT_WR/SHIFT path), pad count +1.
  - Else go to ERROR.
- FINISH: done_o=1, go to DONE.
- DONE / ERROR: terminal until start_i. start_i clears done_o/err_o/word_count_o and goes to PROG_LOW.

Timing and status:
- busy_o=1 in every state except IDLE, DONE, ERROR.
- Per word: 2 sh_wr_o pulses, never back-to-back cycles. Minimum word period = 2 + 2 + shifter time (512 clk).
- turf_done_i asserting before s_tlast_i does not end the run early; remaining words are still fed.
- start_i while busy_o=1 is ignored.
- s_tvalid_i low in GET_WORD stalls indefinitely (no timeout).

Optional Feature:
TURF_PROG_BITSWAP_EN:
- Defined: bit order within each byte of s_tdata_i is reversed before DAT_WR; pad words are unaffected.
- Undefined: word passed unmodified.

Decomposition:
- Package turf_prog_pkg: state enum, shifter address constants (ADDR_CNT=0, ADDR_DAT=1), CNT_WORD=32'h0000001F, PAD_WORD=32'hFFFFFFFF.
- One sub-module, turf_prog_timer: loadable down-counter with expiry flag, shared by PROG_LOW and WAIT_INIT.

Test Plan:
- Reset then start_i, PROG_PULSE_CLKS=16: prog_b low exactly 16 clk; init_b high at +5 clk; first sh_wr_o addr0 dat 0x1F appears after 2-sample sync.
- 3-word stream 0xAA995566, 0x11223344, 0x20000000 (last), shifter model busy 512 clk, DONE after 1 pad: sh_wr_o sequence 0x1F,0xAA995566,0x1F,0x11223344,0x1F,0x20000000,0x1F,0xFFFFFFFF; done_o=1; word_count_o=3.
- init_b held low, INIT_TIMEOUT_CLKS=100: err_o=1 at 100 clk after PROG_B release; no sh_wr_o.
- DONE never asserts, DONE_PAD_WORDS=2: exactly 2 pad words written, then err_o=1, busy_o=0.
- s_tvalid_i dropped for 50 clk mid-stream, and sh_busy_i low during the 2-cycle guard: no extra writes; stream order preserved.
- rst_i during SHIFT: next cycle prog_b=1, busy_o=0, s_tready_o=0; a fresh start_i restarts from PROG_LOW. With TURF_PROG_BITSWAP_EN, word 0x01020380 written as 0x8040C001.
